uart_hex_streamer: RTL

//  Multi-channel successor of the single-probe UART logger. Captures NUM_CH probe

---
 rtl/uart_hex_streamer.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_hex_streamer.sv
// Captures NUM_CH probe words on each trigger rising edge into a sample FIFO and streams
// each sample as one ASCII hex text line, char by char, over a pipelined Wishbone master.
module uart_hex_streamer #(
    parameter int              NUM_CH      = 2,
    parameter int              PROBE_WIDTH = 16,
    parameter int              FIFO_DEPTH  = 8,
    parameter int              ADDR_W      = 4,
    parameter int              DATA_W      = 32,
    parameter logic [7:0]      SEP_CHAR    = 8'h20,
    parameter bit              EOL_LF      = 1'b1,
    parameter bit              POLL_STATUS = 1'b1,
    parameter logic [ADDR_W-1:0] TX_ADDR   = 4'h4,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 4'h8
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic [NUM_CH*PROBE_WIDTH-1:0]     probe_i,
    input  logic                              trig_i,
    output logic                              wb_cyc_o,
    output logic                              wb_stb_o,
    output logic                              wb_we_o,
    output logic [ADDR_W-1:0]                 wb_addr_o,
    output logic [DATA_W-1:0]                 wb_data_o,
    input  logic                              wb_stall_i,
    input  logic [DATA_W-1:0]                 wb_data_i,
    input  logic                              wb_ack_i,
    output logic                              busy_o,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_level_o,
    output logic [15:0]                       drop_cnt_o
);

    localparam int NIB   = PROBE_WIDTH / 4;
    localparam int SW    = NUM_CH * PROBE_WIDTH;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CH_W  = $clog2(NUM_CH + 1);
    localparam int NIB_W = $clog2(NIB + 1);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  TERM_CH  = CH_W'(NUM_CH);
    localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIB - 1);
    localparam logic [NIB_W-1:0] SEP_NIB  = NIB_W'(NIB);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_POLL       = 3'd1;
    localparam logic [2:0] S_POLL_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE      = 3'd3;
    localparam logic [2:0] S_WRITE_WAIT = 3'd4;
    localparam logic [2:0] S_GAP        = 3'd5;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            hex_char = 8'h30 + {4'h0, nib};
        end else begin
            hex_char = 8'h37 + {4'h0, nib};
        end
    endfunction

    logic [SW-1:0]          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic [15:0]            r_drop;
    logic                   r_trig_q;
    logic [2:0]             r_state;
    logic                   r_gap_wr;
    logic [CH_W-1:0]        r_ch;
    logic [NIB_W-1:0]       r_nib;
    logic                   r_cyc;
    logic                   r_stb;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_data;
    logic                   r_busy;

    logic                   w_rise;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_adv;
    logic                   w_last;
    logic [LVL_W-1:0]       w_level_nx;
    logic [SW-1:0]          w_head;
    logic [PROBE_WIDTH-1:0] w_word;
    logic [3:0]             w_nibble;
    logic [7:0]             w_char;
    logic [CH_W-1:0]        w_ch_nx;
    logic [NIB_W-1:0]       w_nib_nx;
    logic [2:0]             w_state_nx;
    logic                   w_gap_wr_nx;
    logic                   w_cyc_nx;
    logic                   w_stb_nx;
    logic                   w_we_nx;
    logic [ADDR_W-1:0]      w_addr_nx;
    logic [DATA_W-1:0]      w_data_nx;
    logic                   w_unused_data;

    assign w_rise        = trig_i & ~r_trig_q;
    assign w_full        = (r_level == FULL_LVL);
    assign w_push        = w_rise & ~w_full;
    assign w_head        = r_mem[r_rd_ptr];
    assign w_unused_data = ^{wb_data_i[DATA_W-1:4], wb_data_i[2:0]};

    // Pick the current head-sample channel and digit as OR-masked selects.
    always_comb begin
        w_word   = {PROBE_WIDTH{1'b0}};
        w_nibble = 4'h0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_word = w_word | (w_head[k*PROBE_WIDTH +: PROBE_WIDTH] & {PROBE_WIDTH{r_ch == CH_W'(k)}});
        end
        for (int j = 0; j < NIB; j++) begin
            w_nibble = w_nibble | (w_word[(NIB-1-j)*4 +: 4] & {4{r_nib == NIB_W'(j)}});
        end
    end

    // Character at the current position; r_ch == NUM_CH marks the line terminator.
    always_comb begin
        if (r_ch == TERM_CH) begin
            w_char = (r_nib == NIB_W'(0)) ? 8'h0D : 8'h0A;
        end else if (r_nib == SEP_NIB) begin
            w_char = SEP_CHAR;
        end else begin
            w_char = hex_char(w_nibble);
        end
        w_last = (r_ch == TERM_CH) && (EOL_LF ? (r_nib == NIB_W'(1)) : (r_nib == NIB_W'(0)));
    end

    // Position advance: digits, then separator (except after the last channel), then CR/LF.
    always_comb begin
        w_ch_nx  = r_ch;
        w_nib_nx = r_nib;
        if (!w_adv) begin
            w_ch_nx  = r_ch;
        end else if (w_last) begin
            w_ch_nx  = CH_W'(0);
            w_nib_nx = NIB_W'(0);
        end else if (r_ch == TERM_CH) begin
            w_nib_nx = NIB_W'(1);
        end else if (r_nib == SEP_NIB) begin
            w_ch_nx  = r_ch + CH_W'(1);
            w_nib_nx = NIB_W'(0);
        end else if (r_nib == LAST_NIB) begin
            if (r_ch == LAST_CH) begin
                w_ch_nx  = TERM_CH;
                w_nib_nx = NIB_W'(0);
            end else begin
                w_nib_nx = SEP_NIB;
            end
        end else begin
            w_nib_nx = r_nib + NIB_W'(1);
        end
    end

    // Bus sequencer; GAP guarantees cyc low for one cycle between back-to-back transfers.
    always_comb begin
        w_state_nx  = r_state;
        w_gap_wr_nx = r_gap_wr;
        w_pop       = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_level != {LVL_W{1'b0}}) begin
                    w_state_nx = POLL_STATUS ? S_POLL : S_WRITE;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_POLL: begin
                w_state_nx = wb_stall_i ? S_POLL : S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (wb_ack_i) begin
                    w_state_nx  = S_GAP;
                    w_gap_wr_nx = ~wb_data_i[3];
                end else begin
                    w_state_nx  = S_POLL_WAIT;
                end
            end
            S_WRITE: begin
                w_state_nx = wb_stall_i ? S_WRITE : S_WRITE_WAIT;
            end
            S_WRITE_WAIT: begin
                if (wb_ack_i) begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_pop      = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx  = S_GAP;
                        w_gap_wr_nx = ~POLL_STATUS;
                    end
                end else begin
                    w_state_nx = S_WRITE_WAIT;
                end
            end
            S_GAP: begin
                w_state_nx = r_gap_wr ? S_WRITE : S_POLL;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Bus outputs decoded from the next state so they leave the block registered.
    always_comb begin
        w_cyc_nx  = 1'b0;
        w_stb_nx  = 1'b0;
        w_we_nx   = 1'b0;
        w_addr_nx = {ADDR_W{1'b0}};
        w_data_nx = {DATA_W{1'b0}};
        case (w_state_nx)
            S_POLL: begin
                w_cyc_nx  = 1'b1;
                w_stb_nx  = 1'b1;
                w_addr_nx = STAT_ADDR;
            end
            S_POLL_WAIT: begin
                w_cyc_nx  = 1'b1;
                w_addr_nx = STAT_ADDR;
            end
            S_WRITE: begin
                w_cyc_nx  = 1'b1;
                w_stb_nx  = 1'b1;
                w_we_nx   = 1'b1;
                w_addr_nx = TX_ADDR;
                w_data_nx = {{(DATA_W-8){1'b0}}, w_char};
            end
            S_WRITE_WAIT: begin
                w_cyc_nx  = 1'b1;
                w_we_nx   = 1'b1;
                w_addr_nx = TX_ADDR;
                w_data_nx = {{(DATA_W-8){1'b0}}, w_char};
            end
            default: begin
                w_cyc_nx  = 1'b0;
            end
        endcase
    end

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        case ({w_push, w_pop})
            2'b10:   w_level_nx = r_level + LVL_W'(1);
            2'b01:   w_level_nx = r_level - LVL_W'(1);
            default: w_level_nx = r_level;
        endcase
    end

    // Sample storage (data only, pointers carry the valid state).
    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= probe_i;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_level  <= {LVL_W{1'b0}};
            r_drop   <= 16'h0000;
            r_trig_q <= 1'b0;
            r_state  <= S_IDLE;
            r_gap_wr <= 1'b0;
            r_ch     <= {CH_W{1'b0}};
            r_nib    <= {NIB_W{1'b0}};
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= {ADDR_W{1'b0}};
            r_data   <= {DATA_W{1'b0}};
            r_busy   <= 1'b0;
        end else begin
            r_trig_q <= trig_i;
            r_wr_ptr <= w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
            r_level  <= w_level_nx;
            r_drop   <= (w_rise && w_full && (r_drop != 16'hFFFF)) ? r_drop + 16'd1 : r_drop;
            r_state  <= w_state_nx;
            r_gap_wr <= w_gap_wr_nx;
            r_ch     <= w_ch_nx;
            r_nib    <= w_nib_nx;
            r_cyc    <= w_cyc_nx;
            r_stb    <= w_stb_nx;
            r_we     <= w_we_nx;
            r_addr   <= w_addr_nx;
            r_data   <= w_data_nx;
            r_busy   <= (w_state_nx != S_IDLE) || (w_level_nx != {LVL_W{1'b0}});
        end
    end

    assign wb_cyc_o     = r_cyc;
    assign wb_stb_o     = r_stb;
    assign wb_we_o      = r_we;
    assign wb_addr_o    = r_addr;
    assign wb_data_o    = r_data;
    assign busy_o       = r_busy;
    assign fifo_level_o = r_level;
    assign drop_cnt_o   = r_drop;

endmodule
